retire_monitor: RTL and testbench
=================================

Name: retire_monitor

Overview:
Synthesizable run-control and retirement monitor for SoC simulation and FPGA bring-up. It replaces the ad-hoc bench logic for core reset hold, timeout and instruction counting. It generalises single-channel writeback counting to RETIRE_W parallel retire channels, and adds an end-PC pass detector, a hang watchdog, a cycle counter and a sticky status result. It sits beside the CPU and observes the writeback/retire ports; it drives the core's reset.

Parameters:
RETIRE_W, 2, number of retire channels per cycle (1..8)
PC_W, 64, retire PC width
CNT_W, 32, width of instruction and cycle counters
RST_HOLD, 25, cycles io_coreReset is held after io_reset deasserts (>=1)
TIMEOUT, 27500, RUN cycles before timeout (>=1)
HANG_LIMIT, 1024, consecutive RUN cycles with no retirement that flag a hang (>=1)

Ports:
io_axiClk  in  1  clock, all logic on rising edge
io_reset  in  1  synchronous active-high reset
io_retire_valid  in  RETIRE_W  per-channel retire strobe (writeback firing)
io_retire_pc  in  RETIRE_W*PC_W  per-channel retire PC, channel i at [i*PC_W +: PC_W]
io_end_pc  in  PC_W  PC whose retirement ends the run with PASS; sampled every cycle
io_coreReset  out  1  reset to the core, active high
io_instrCnt  out  CNT_W  retired-instruction count
io_cycleCnt  out  CNT_W  cycles spent in RUN
io_lastPc  out  PC_W  PC of the most recent retirement
io_status  out  2  0=RUNNING, 1=PASS, 2=TIMEOUT, 3=HANG
io_done  out  1  high in any terminal state

Behaviour:
- Clock and reset: one clock, io_axiClk. Reset io_reset is synchronous and active-high.
- While io_reset is high (at that edge): state=HOLD, io_coreReset=1, all counters=0, io_lastPc=0, io_status=0, io_done=0. A reset asserted mid-run aborts the run and restores these values on the next edge.
- FSM states: HOLD, RUN, PASS, TIMEOUT, HANG. PASS, TIMEOUT and HANG are terminal and sticky until io_reset.
- HOLD:
  - A hold counter counts RST_HOLD cycles after reset deasserts, then the FSM enters RUN.
  - io_coreReset=1 throughout HOLD and deasserts (registered) on the first RUN cycle.
  - Retire inputs are ignored in HOLD.
- RUN, each cycle:
  - cycleCnt += 1.
  - instrCnt += popcount(io_retire_valid). Both counters saturate at all-ones and never wrap.
  - io_lastPc = PC of the highest-index valid channel. It holds when no channel is valid.
  - The hang counter clears on any valid channel; otherwise it increments.
- Transitions out of RUN, evaluated on the same edge the counters update. Priority is PASS > HANG > TIMEOUT:
  - PASS: any channel has valid=1 and pc==io_end_pc. All valid channels in that cycle are still counted.
  - HANG: hang counter reaches HANG_LIMIT-1 with no valid this cycle, i.e. exactly HANG_LIMIT idle cycles.
  - TIMEOUT: cycleCnt reaches TIMEOUT-1 before increment, i.e. the TIMEOUT-th RUN cycle.
- Terminal states:
  - Counters and io_lastPc freeze.
  - io_coreReset reasserts (1) to quiesce the core.
  - io_done=1 and io_status encodes the state, both registered. They become visible the cycle after the deciding edge.
- Counter widths:
  - Internal popcount width is $clog2(RETIRE_W+1), zero-extended to CNT_W.
  - Hang and hold counters are sized with $clog2 of their limit plus 1.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package retire_monitor_pkg:
  - state enum (HOLD, RUN, PASS, TIMEOUT, HANG)
  - 2-bit status encoding constants (STATUS_RUNNING, STATUS_PASS, STATUS_TIMEOUT, STATUS_HANG)
  - saturating-add function
- One sub-module, retire_popcount:
  - Parametrised by RETIRE_W.
  - Purely combinational count of set bits in io_retire_valid.
  - Reused by future performance-counter blocks.

Test Plan:
- Reset release: io_reset high 3 cycles then low, RST_HOLD=25 -> io_coreReset=1 for exactly 25 cycles after release, then 0; counters 0 on the first RUN cycle.
- Dual retire count: RETIRE_W=2, valid=2'b11 for 10 cycles then 2'b01 for 5 cycles -> io_instrCnt=25, io_lastPc equals the channel-1 PC of cycle 10 until the first 2'b01 cycle.
- End PC: io_end_pc=0x8000_0100, channel 0 retires 0x8000_00FC and channel 1 retires 0x8000_0100 in the same cycle -> status=PASS, io_done=1 the next cycle, instrCnt includes both, io_coreReset=1.
- Hang: HANG_LIMIT=16, retire each cycle for 20 cycles then none -> HANG on the 16th idle cycle; io_status=3; instrCnt=20 frozen.
- Timeout with priority: TIMEOUT=100 and the end-PC retirement lands on RUN cycle 100 -> PASS, not TIMEOUT. Without that retirement -> TIMEOUT with io_cycleCnt=100.
- Mid-run reset: assert io_reset during RUN at instrCnt=40 -> next edge instrCnt=0, status=0, io_coreReset=1, and the HOLD sequence restarts.

Source files
------------

// File: rtl/retire_monitor_pkg.sv
// -----------------------------------------------------------------------------
// retire_monitor_pkg
// Shared types and helpers for the run-control / retirement monitor:
//   - state_e        : monitor FSM states
//   - STATUS_*       : 2-bit encoding reported on io_status
//   - sat_add()      : saturating add at a caller-chosen width (1..64 bits)
// -----------------------------------------------------------------------------
package retire_monitor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_RUNNING = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd2;
  localparam logic [1:0] STATUS_HANG    = 2'd3;

  // Adds a and b, clamping at the all-ones value of a 'width'-bit counter.
  // Operands are carried at 64 bits so one helper serves every counter width.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [63:0] max_val;
    if (width >= 32'd64) begin
      max_val = {64{1'b1}};
    end else begin
      max_val = (64'd1 << width) - 64'd1;
    end
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/retire_popcount.sv
// -----------------------------------------------------------------------------
// retire_popcount
// Combinational count of asserted retire strobes.
//   io_retire_valid [RETIRE_W]          : per-channel retire strobes
//   count           [$clog2(RETIRE_W+1)]: number of strobes set
// -----------------------------------------------------------------------------
module retire_popcount
  import retire_monitor_pkg::*;
#(
  parameter int RETIRE_W = 2
) (
  input  logic [RETIRE_W-1:0]              io_retire_valid,
  output logic [$clog2(RETIRE_W+1)-1:0]    count
);

  localparam int CW = $clog2(RETIRE_W + 1);

  // Sum of set bits across all channels
  always_comb begin
    count = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      count = count + CW'(io_retire_valid[i]);
    end
  end

endmodule

// File: rtl/retire_monitor.sv
// -----------------------------------------------------------------------------
// retire_monitor
// Holds the core in reset after io_reset, then watches the retire ports:
// counts retired instructions and RUN cycles, tracks the last retired PC and
// ends the run with PASS (end PC retired), HANG (too long without retirement)
// or TIMEOUT (RUN cycle budget spent). Terminal states are sticky until reset.
// Ports:
//   io_axiClk, io_reset      : clock, synchronous active-high reset
//   io_retire_valid/_pc      : RETIRE_W retire channels, PC i at [i*PC_W +: PC_W]
//   io_end_pc                : PC whose retirement means PASS
//   io_coreReset             : reset to the core (high in HOLD and terminal states)
//   io_instrCnt, io_cycleCnt : saturating instruction / RUN-cycle counters
//   io_lastPc                : PC of the most recent retirement
//   io_status, io_done       : 0 RUNNING, 1 PASS, 2 TIMEOUT, 3 HANG; done = terminal
// -----------------------------------------------------------------------------
module retire_monitor
  import retire_monitor_pkg::*;
#(
  parameter int RETIRE_W   = 2,
  parameter int PC_W       = 64,
  parameter int CNT_W      = 32,
  parameter int RST_HOLD   = 25,
  parameter int TIMEOUT    = 27500,
  parameter int HANG_LIMIT = 1024
) (
  input  logic                     io_axiClk,
  input  logic                     io_reset,
  input  logic [RETIRE_W-1:0]      io_retire_valid,
  input  logic [RETIRE_W*PC_W-1:0] io_retire_pc,
  input  logic [PC_W-1:0]          io_end_pc,
  output logic                     io_coreReset,
  output logic [CNT_W-1:0]         io_instrCnt,
  output logic [CNT_W-1:0]         io_cycleCnt,
  output logic [PC_W-1:0]          io_lastPc,
  output logic [1:0]               io_status,
  output logic                     io_done
);

  localparam int POP_W  = $clog2(RETIRE_W + 1);
  localparam int HOLD_W = $clog2(RST_HOLD) + 1;
  localparam int HANG_W = $clog2(HANG_LIMIT) + 1;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [HANG_W-1:0]  hang_cnt_q, hang_cnt_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic [1:0]         status_q, status_d;
  logic               done_q, done_d;
  logic               core_reset_q, core_reset_d;

  logic [POP_W-1:0]   pop_count;
  logic [PC_W-1:0]    top_pc;
  logic               any_valid, end_hit, hang_hit, timeout_hit;

  retire_popcount #(.RETIRE_W(RETIRE_W)) u_popcount (
    .io_retire_valid (io_retire_valid),
    .count           (pop_count)
  );

  // Per-cycle decode of the retire channels; the highest valid channel wins top_pc
  always_comb begin
    end_hit = 1'b0;
    top_pc  = last_pc_q;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (io_retire_valid[i]) begin
        top_pc = io_retire_pc[i*PC_W +: PC_W];
        if (io_retire_pc[i*PC_W +: PC_W] == io_end_pc) begin
          end_hit = 1'b1;
        end else begin
          end_hit = end_hit;
        end
      end else begin
        top_pc = top_pc;
      end
    end
    any_valid   = |io_retire_valid;
    // Idle this cycle would make HANG_LIMIT consecutive idle cycles
    hang_hit    = !any_valid && (hang_cnt_q == HANG_W'(HANG_LIMIT - 1));
    // Pre-increment compare: this is the TIMEOUT-th RUN cycle
    timeout_hit = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // FSM next state; PASS beats HANG beats TIMEOUT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (end_hit) begin
          state_d = ST_PASS;
        end else if (hang_hit) begin
          state_d = ST_HANG;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PASS, ST_TIMEOUT, ST_HANG: state_d = state_q;
      default: state_d = ST_HOLD;
    endcase
  end

  // Counter datapath: hold counter in HOLD, everything else only in RUN
  always_comb begin
    hold_cnt_d  = hold_cnt_q;
    hang_cnt_d  = hang_cnt_q;
    instr_cnt_d = instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    last_pc_d   = last_pc_q;
    if (state_q == ST_HOLD) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end else if (state_q == ST_RUN) begin
      cycle_cnt_d = CNT_W'(sat_add(64'(cycle_cnt_q), 64'd1, CNT_W));
      instr_cnt_d = CNT_W'(sat_add(64'(instr_cnt_q), 64'(pop_count), CNT_W));
      last_pc_d   = top_pc;
      if (any_valid) begin
        hang_cnt_d = '0;
      end else begin
        hang_cnt_d = hang_cnt_q + HANG_W'(1);
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Outputs that follow the state being entered, so they register with it
  always_comb begin
    core_reset_d = 1'b1;
    status_d     = STATUS_RUNNING;
    done_d       = 1'b0;
    case (state_d)
      ST_HOLD:    core_reset_d = 1'b1;
      ST_RUN:     core_reset_d = 1'b0;
      ST_PASS:    begin status_d = STATUS_PASS;    done_d = 1'b1; end
      ST_TIMEOUT: begin status_d = STATUS_TIMEOUT; done_d = 1'b1; end
      ST_HANG:    begin status_d = STATUS_HANG;    done_d = 1'b1; end
      default:    core_reset_d = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter and output registers
  always_ff @(posedge io_axiClk) begin
    if (io_reset) begin
      hold_cnt_q   <= '0;
      hang_cnt_q   <= '0;
      instr_cnt_q  <= '0;
      cycle_cnt_q  <= '0;
      last_pc_q    <= '0;
      status_q     <= STATUS_RUNNING;
      done_q       <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      hang_cnt_q   <= hang_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      last_pc_q    <= last_pc_d;
      status_q     <= status_d;
      done_q       <= done_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign io_coreReset = core_reset_q;
  assign io_instrCnt  = instr_cnt_q;
  assign io_cycleCnt  = cycle_cnt_q;
  assign io_lastPc    = last_pc_q;
  assign io_status    = status_q;
  assign io_done      = done_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: two instances (wide counters / 4-bit saturating
// counters) share one stimulus stream; a behavioural model of each is stepped
// every edge and all outputs are compared, plus directed scenario checks.
module tb_retire_monitor;

  localparam int A_CNT_W = 32, A_HOLD = 25, A_TO = 100, A_HANG = 16;
  localparam int B_CNT_W = 4,  B_HOLD = 3,  B_TO = 12,  B_HANG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    valid;
  logic [127:0]  pcs;
  logic [63:0]   end_pc, end_pc_b;

  logic          a_core, a_done, b_core, b_done;
  logic [31:0]   a_instr, a_cyc;
  logic [3:0]    b_instr, b_cyc;
  logic [63:0]   a_last, b_last;
  logic [1:0]    a_status, b_status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              phase;   // 0 holding, 1 running, 2 finished
    int              hold;
    longint unsigned cyc;
    longint unsigned instr;
    logic [63:0]     last_pc;
    int              idle;
    int              status;
    bit              done;
    bit              core;
  } model_t;

  model_t ma, mb;

  retire_monitor #(.RETIRE_W(2), .PC_W(64), .CNT_W(A_CNT_W), .RST_HOLD(A_HOLD),
                   .TIMEOUT(A_TO), .HANG_LIMIT(A_HANG)) dut_a (
    .io_axiClk(clk), .io_reset(rst), .io_retire_valid(valid), .io_retire_pc(pcs),
    .io_end_pc(end_pc), .io_coreReset(a_core), .io_instrCnt(a_instr),
    .io_cycleCnt(a_cyc), .io_lastPc(a_last), .io_status(a_status), .io_done(a_done));

  retire_monitor #(.RETIRE_W(2), .PC_W(64), .CNT_W(B_CNT_W), .RST_HOLD(B_HOLD),
                   .TIMEOUT(B_TO), .HANG_LIMIT(B_HANG)) dut_b (
    .io_axiClk(clk), .io_reset(rst), .io_retire_valid(valid), .io_retire_pc(pcs),
    .io_end_pc(end_pc_b), .io_coreReset(b_core), .io_instrCnt(b_instr),
    .io_cycleCnt(b_cyc), .io_lastPc(b_last), .io_status(b_status), .io_done(b_done));

  always #5 clk = ~clk;

  // Behavioural reference: one clock edge of the monitor.
  function automatic model_t model_step(model_t m, bit r, logic [1:0] v, logic [127:0] p,
                                        logic [63:0] ep, int hold_lim, int to_lim,
                                        int hang_lim, longint unsigned cmax);
    model_t n;
    int k;
    bit pass;
    n = m;
    if (r) begin
      n.phase = 0; n.hold = 0; n.cyc = 0; n.instr = 0; n.last_pc = '0;
      n.idle = 0; n.status = 0; n.done = 1'b0; n.core = 1'b1;
      return n;
    end
    if (m.phase == 0) begin
      n.hold = m.hold + 1;
      if (n.hold == hold_lim) begin
        n.phase = 1;
        n.core  = 1'b0;
      end
    end else if (m.phase == 1) begin
      k    = $countones(v);
      pass = (v[0] && p[63:0] == ep) || (v[1] && p[127:64] == ep);
      n.cyc   = (m.cyc + 1 > cmax) ? cmax : m.cyc + 1;
      n.instr = (m.instr + longint'(k) > cmax) ? cmax : m.instr + longint'(k);
      if (v[1]) n.last_pc = p[127:64];
      else if (v[0]) n.last_pc = p[63:0];
      n.idle = (k > 0) ? 0 : m.idle + 1;
      if (pass) n.status = 1;
      else if (n.idle == hang_lim) n.status = 3;
      else if (n.cyc == longint'(to_lim)) n.status = 2;
      if (n.status != 0) begin
        n.phase = 2;
        n.done  = 1'b1;
        n.core  = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand_pc();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one cycle, advance both models, sample outputs 1 time unit after the edge.
  task automatic step(input bit r, input logic [1:0] v, input logic [127:0] p);
    rst = r; valid = v; pcs = p;
    @(posedge clk);
    ma = model_step(ma, r, v, p, end_pc,   A_HOLD, A_TO, A_HANG, 64'hFFFF_FFFF);
    mb = model_step(mb, r, v, p, end_pc_b, B_HOLD, B_TO, B_HANG, 64'd15);
    #1;
    chk("a_core",   a_core,   ma.core);
    chk("a_instr",  a_instr,  ma.instr);
    chk("a_cycle",  a_cyc,    ma.cyc);
    chk("a_lastpc", a_last,   ma.last_pc);
    chk("a_status", a_status, ma.status);
    chk("a_done",   a_done,   ma.done);
    chk("b_core",   b_core,   mb.core);
    chk("b_instr",  b_instr,  mb.instr);
    chk("b_cycle",  b_cyc,    mb.cyc);
    chk("b_lastpc", b_last,   mb.last_pc);
    chk("b_status", b_status, mb.status);
    chk("b_done",   b_done,   mb.done);
  endtask

  // Reset for n cycles, then the full hold window with end-PC retirements that must be ignored.
  task automatic reset_and_hold(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b00, '0);
    chk("rst_core", a_core, 1'b1);
    chk("rst_instr", a_instr, 32'd0);
    for (int k = 1; k <= A_HOLD; k++) begin
      step(1'b0, 2'b11, {rand_pc(), end_pc});
      chk("hold_core", a_core, (k < A_HOLD) ? 1'b1 : 1'b0);
    end
    chk("run_instr0", a_instr, 32'd0);
    chk("run_cycle0", a_cyc, 32'd0);
    chk("run_status0", a_status, 2'd0);
  endtask

  initial begin
    logic [63:0] pc1_keep, pc0_now;
    end_pc   = 64'h8000_0100;
    end_pc_b = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b1; valid = '0; pcs = '0;

    // Reset release and dual retire counting, ending in TIMEOUT
    reset_and_hold(3);
    for (int i = 0; i < 10; i++) begin
      pc1_keep = rand_pc();
      step(1'b0, 2'b11, {pc1_keep, rand_pc()});
    end
    chk("dual_lastpc", a_last, pc1_keep);
    pc0_now = rand_pc();
    step(1'b0, 2'b01, {rand_pc(), pc0_now});
    chk("single_lastpc", a_last, pc0_now);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b01, {rand_pc(), rand_pc()});
    chk("dual_instr", a_instr, 32'd25);
    for (int i = 0; i < 85; i++)
      step(1'b0, 2'($urandom_range(1, 3)), {rand_pc(), rand_pc()});
    chk("to_status", a_status, 2'd2);
    chk("to_cycle", a_cyc, 32'd100);
    chk("to_core", a_core, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, {end_pc, end_pc});
    chk("to_sticky", a_status, 2'd2);
    chk("to_frozen", a_cyc, 32'd100);

    // End PC on channel 1 alongside channel 0
    reset_and_hold(1);
    for (int i = 0; i < 7; i++) step(1'b0, 2'b01, {rand_pc(), rand_pc()});
    step(1'b0, 2'b11, {end_pc, 64'h8000_00FC});
    chk("pass_status", a_status, 2'd1);
    chk("pass_done", a_done, 1'b1);
    chk("pass_instr", a_instr, 32'd9);
    chk("pass_core", a_core, 1'b1);

    // Hang after exactly HANG_LIMIT idle cycles
    reset_and_hold(2);
    for (int i = 0; i < 20; i++) step(1'b0, 2'b01, {rand_pc(), rand_pc()});
    for (int j = 1; j <= A_HANG; j++) begin
      step(1'b0, 2'b00, {rand_pc(), rand_pc()});
      chk("hang_status", a_status, (j == A_HANG) ? 2'd3 : 2'd0);
    end
    step(1'b0, 2'b11, {rand_pc(), rand_pc()});
    chk("hang_instr", a_instr, 32'd20);

    // End PC on the TIMEOUT-th cycle: PASS wins
    reset_and_hold(1);
    for (int i = 0; i < A_TO - 1; i++)
      step(1'b0, 2'($urandom_range(1, 3)), {rand_pc(), rand_pc()});
    step(1'b0, 2'b01, {rand_pc(), end_pc});
    chk("prio_status", a_status, 2'd1);
    chk("prio_cycle", a_cyc, 32'd100);

    // Reset in the middle of a run
    reset_and_hold(1);
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, {rand_pc(), rand_pc()});
    chk("mid_instr", a_instr, 32'd40);
    reset_and_hold(1);
    for (int i = 0; i < 30; i++)
      step(1'b0, 2'($urandom_range(0, 3)), {rand_pc(), rand_pc()});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
